tag_fill_writer: RTL and testbench

TAG_FILL_WRITER -- requirements
Module: tag_fill_writer

---
 rtl/tag_fill_writer.sv | 180 ++++++++++++++++++
 tb/tb_tag_fill_writer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_fill_writer.sv
// -----------------------------------------------------------------------------
// tag_fill_writer
//
// Write-port sequencer for a small direct-mapped tag array. After reset it
// sweeps every set and writes an invalid entry to each one, then raises
// init_done_o. After that it accepts one fill (tag + valid bit) or one
// invalidate (valid bit cleared) at a time. It turns each request into a
// single registered array write, followed by a one-cycle wr_done_o pulse.
//
// Ports
//   clk_i          : clock, all state changes on the rising edge
//   rst_n_i        : synchronous active-low reset
//   fill_valid_i   : fill request present
//   fill_ready_o   : fill can be accepted this cycle (combinational)
//   fill_index_i   : set to fill
//   fill_tag_i     : tag to store
//   inval_valid_i  : invalidate request present
//   inval_ready_o  : invalidate can be accepted this cycle (combinational)
//   inval_index_i  : set to invalidate
//   arr_we_o       : tag-array write enable (registered)
//   arr_addr_o     : tag-array write address (registered)
//   arr_tag_o      : tag-array write data (registered)
//   arr_vbit_o     : valid bit written alongside arr_tag_o (registered)
//   init_done_o    : sticky, high once the power-on sweep has finished
//   wr_done_o      : one-cycle pulse after each request write
// -----------------------------------------------------------------------------
module tag_fill_writer #(
  parameter int TAG_W   = 4,
  parameter int INDEX_W = 2
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               fill_valid_i,
  output logic               fill_ready_o,
  input  logic [INDEX_W-1:0] fill_index_i,
  input  logic [TAG_W-1:0]   fill_tag_i,
  input  logic               inval_valid_i,
  output logic               inval_ready_o,
  input  logic [INDEX_W-1:0] inval_index_i,
  output logic               arr_we_o,
  output logic [INDEX_W-1:0] arr_addr_o,
  output logic [TAG_W-1:0]   arr_tag_o,
  output logic               arr_vbit_o,
  output logic               init_done_o,
  output logic               wr_done_o
);

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [INDEX_W-1:0] LAST_IDX = {INDEX_W{1'b1}};
  localparam logic [INDEX_W-1:0] IDX_ONE  = {{(INDEX_W-1){1'b0}}, 1'b1};

  logic [1:0]         state_q,     state_d;
  logic [INDEX_W-1:0] cnt_q,       cnt_d;
  logic               arr_we_q,    arr_we_d;
  logic [INDEX_W-1:0] arr_addr_q,  arr_addr_d;
  logic [TAG_W-1:0]   arr_tag_q,   arr_tag_d;
  logic               arr_vbit_q,  arr_vbit_d;
  logic               init_done_q, init_done_d;
  logic               wr_done_q,   wr_done_d;

  // Handshake readiness: an invalidate always wins over a fill in IDLE.
  assign inval_ready_o = (state_q == ST_IDLE);
  assign fill_ready_o  = (state_q == ST_IDLE) & ~inval_valid_i;

  // Next-state and next-output logic for the sweep / request FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    arr_we_d    = arr_we_q;
    arr_addr_d  = arr_addr_q;
    arr_tag_d   = arr_tag_q;
    arr_vbit_d  = arr_vbit_q;
    init_done_d = init_done_q;
    wr_done_d   = wr_done_q;

    case (state_q)
      ST_INIT: begin
        wr_done_d = 1'b0;
        // The last sweep write is already on the outputs, so end the sweep.
        if (arr_we_q && (arr_addr_q == LAST_IDX)) begin
          arr_we_d    = 1'b0;
          init_done_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          arr_we_d   = 1'b1;
          arr_addr_d = cnt_q;
          arr_tag_d  = {TAG_W{1'b0}};
          arr_vbit_d = 1'b0;
          // Saturate at the last set; the counter never wraps.
          if (cnt_q != LAST_IDX) begin
            cnt_d = cnt_q + IDX_ONE;
          end else begin
            cnt_d = cnt_q;
          end
        end
      end

      ST_IDLE: begin
        arr_we_d  = 1'b0;
        wr_done_d = 1'b0;
        // Accepting a request loads the write registers directly. The
        // request is then captured and ignores any later input changes.
        if (inval_valid_i) begin
          arr_we_d   = 1'b1;
          arr_addr_d = inval_index_i;
          arr_tag_d  = {TAG_W{1'b0}};
          arr_vbit_d = 1'b0;
          state_d    = ST_WRITE;
        end else if (fill_valid_i) begin
          arr_we_d   = 1'b1;
          arr_addr_d = fill_index_i;
          arr_tag_d  = fill_tag_i;
          arr_vbit_d = 1'b1;
          state_d    = ST_WRITE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WRITE: begin
        arr_we_d  = 1'b0;
        wr_done_d = 1'b1;
        state_d   = ST_DONE;
      end

      ST_DONE: begin
        arr_we_d  = 1'b0;
        wr_done_d = 1'b0;
        state_d   = ST_IDLE;
      end

      default: begin
        // Unreachable encoding: fall back to a fresh sweep.
        state_d     = ST_INIT;
        cnt_d       = {INDEX_W{1'b0}};
        arr_we_d    = 1'b0;
        arr_addr_d  = {INDEX_W{1'b0}};
        arr_tag_d   = {TAG_W{1'b0}};
        arr_vbit_d  = 1'b0;
        init_done_d = 1'b0;
        wr_done_d   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_INIT;
      cnt_q       <= {INDEX_W{1'b0}};
      arr_we_q    <= 1'b0;
      arr_addr_q  <= {INDEX_W{1'b0}};
      arr_tag_q   <= {TAG_W{1'b0}};
      arr_vbit_q  <= 1'b0;
      init_done_q <= 1'b0;
      wr_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      arr_we_q    <= arr_we_d;
      arr_addr_q  <= arr_addr_d;
      arr_tag_q   <= arr_tag_d;
      arr_vbit_q  <= arr_vbit_d;
      init_done_q <= init_done_d;
      wr_done_q   <= wr_done_d;
    end
  end

  assign arr_we_o    = arr_we_q;
  assign arr_addr_o  = arr_addr_q;
  assign arr_tag_o   = arr_tag_q;
  assign arr_vbit_o  = arr_vbit_q;
  assign init_done_o = init_done_q;
  assign wr_done_o   = wr_done_q;

endmodule

// File: tb/tb_tag_fill_writer.sv
// -----------------------------------------------------------------------------
// tb_tag_fill_writer
//
// Self-checking bench for tag_fill_writer with default parameters. A timeline
// model counts rising edges since reset release (k) and remembers the edge at
// which the last request was accepted (a). Every registered output follows
// from these two numbers with plain arithmetic. A directed sequence pins the
// model with literal values, and a randomized phase with hold-until-accepted
// requesters and occasional resets follows it.
// -----------------------------------------------------------------------------
module tb_tag_fill_writer;

  localparam int TAG_W   = 4;
  localparam int INDEX_W = 2;
  localparam int NS      = 1 << INDEX_W;

  logic               clk;
  logic               rst_n;
  logic               fill_valid;
  logic               fill_ready;
  logic [INDEX_W-1:0] fill_index;
  logic [TAG_W-1:0]   fill_tag;
  logic               inval_valid;
  logic               inval_ready;
  logic [INDEX_W-1:0] inval_index;
  logic               arr_we;
  logic [INDEX_W-1:0] arr_addr;
  logic [TAG_W-1:0]   arr_tag;
  logic               arr_vbit;
  logic               init_done;
  logic               wr_done;

  int errors = 0;
  int checks = 0;

  tag_fill_writer #(.TAG_W(TAG_W), .INDEX_W(INDEX_W)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .fill_valid_i  (fill_valid),
    .fill_ready_o  (fill_ready),
    .fill_index_i  (fill_index),
    .fill_tag_i    (fill_tag),
    .inval_valid_i (inval_valid),
    .inval_ready_o (inval_ready),
    .inval_index_i (inval_index),
    .arr_we_o      (arr_we),
    .arr_addr_o    (arr_addr),
    .arr_tag_o     (arr_tag),
    .arr_vbit_o    (arr_vbit),
    .init_done_o   (init_done),
    .wr_done_o     (wr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural timeline model + compare ----------------
  int               m_k       = 0;     // edges since reset release
  int               m_a       = -100;  // edge at which last request was accepted
  logic             m_rst     = 1'b1;  // last edge had rst_n low
  logic             m_fill    = 1'b0;
  logic [INDEX_W-1:0] m_idx   = '0;
  logic [TAG_W-1:0] m_tag     = '0;
  logic             m_started = 1'b0;

  initial begin
    forever begin
      logic rdy;
      logic sweep;
      logic e_we;
      @(negedge clk);
      if (m_started) begin
        if (m_rst) begin
          chk("rst_we",    arr_we,      0);
          chk("rst_addr",  arr_addr,    0);
          chk("rst_tag",   arr_tag,     0);
          chk("rst_vbit",  arr_vbit,    0);
          chk("rst_init",  init_done,   0);
          chk("rst_wrd",   wr_done,     0);
          chk("rst_frdy",  fill_ready,  0);
          chk("rst_irdy",  inval_ready, 0);
        end else begin
          rdy   = (m_k >= NS + 1) && (m_k >= m_a + 2);
          sweep = (m_k >= 1) && (m_k <= NS);
          e_we  = sweep || (m_k == m_a);
          chk("we",        arr_we,      {31'd0, e_we});
          chk("init_done", init_done,   {31'd0, (m_k >= NS + 1)});
          chk("wr_done",   wr_done,     {31'd0, (m_k == m_a + 1)});
          chk("irdy",      inval_ready, {31'd0, rdy});
          chk("frdy",      fill_ready,  {31'd0, rdy && !inval_valid});
          if (sweep) begin
            chk("sw_addr", arr_addr, m_k - 1);
            chk("sw_tag",  arr_tag,  0);
            chk("sw_vbit", arr_vbit, 0);
          end else if (e_we) begin
            chk("rq_addr", arr_addr, {30'd0, m_idx});
            chk("rq_tag",  arr_tag,  {28'd0, m_tag});
            chk("rq_vbit", arr_vbit, {31'd0, m_fill});
          end
        end
      end
      // Advance the model across the coming rising edge (inputs are stable).
      if (!rst_n) begin
        m_rst = 1'b1;
        m_k   = 0;
        m_a   = -100;
      end else begin
        m_rst = 1'b0;
        rdy   = (m_k >= NS + 1) && (m_k >= m_a + 2);
        if (rdy && inval_valid) begin
          m_a = m_k + 1; m_fill = 1'b0; m_idx = inval_index; m_tag = '0;
        end else if (rdy && fill_valid) begin
          m_a = m_k + 1; m_fill = 1'b1; m_idx = fill_index; m_tag = fill_tag;
        end
        m_k = m_k + 1;
      end
      m_started = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic fpend, ipend, acc_f, acc_i;
    int   rst_cnt;
    rst_n = 1'b0; fill_valid = 1'b0; fill_index = '0; fill_tag = '0;
    inval_valid = 1'b0; inval_index = '0;

    // Early request held through reset and the sweep.
    fill_valid = 1'b1; fill_index = 2'd1; fill_tag = 4'h3;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < NS; i++) begin
      tick();
      chk("lit_sweep_we",   arr_we,   1);
      chk("lit_sweep_addr", arr_addr, i);
      chk("lit_sweep_vbit", arr_vbit, 0);
    end
    tick();  // cycle NS+1
    chk("lit_init_done", init_done,  1);
    chk("lit_fill_rdy",  fill_ready, 1);
    chk("lit_idle_we",   arr_we,     0);
    tick();  // early fill write
    fill_valid = 1'b0;
    chk("lit_early_we",   arr_we,   1);
    chk("lit_early_addr", arr_addr, 1);
    chk("lit_early_tag",  arr_tag,  4'h3);
    tick();
    chk("lit_early_wrd", wr_done, 1);
    chk("lit_early_we0", arr_we,  0);
    tick();

    // Single fill: index 2, tag A.
    fill_valid = 1'b1; fill_index = 2'd2; fill_tag = 4'hA;
    tick();
    fill_valid = 1'b0;
    chk("lit_fill_we",   arr_we,   1);
    chk("lit_fill_addr", arr_addr, 2);
    chk("lit_fill_tag",  arr_tag,  4'hA);
    chk("lit_fill_vbit", arr_vbit, 1);
    tick();
    chk("lit_fill_wrd", wr_done, 1);
    chk("lit_fill_we0", arr_we,  0);
    tick();

    // Collision: invalidate 1 and fill 3/5 together.
    inval_valid = 1'b1; inval_index = 2'd1;
    fill_valid = 1'b1; fill_index = 2'd3; fill_tag = 4'h5;
    #1;
    chk("lit_col_frdy", fill_ready,  0);
    chk("lit_col_irdy", inval_ready, 1);
    tick();
    inval_valid = 1'b0;
    chk("lit_col_inv_addr", arr_addr, 1);
    chk("lit_col_inv_vbit", arr_vbit, 0);
    chk("lit_col_inv_we",   arr_we,   1);
    tick();
    chk("lit_col_wrd", wr_done, 1);
    tick();
    chk("lit_col_frdy2", fill_ready, 1);
    tick();
    fill_valid = 1'b0;
    chk("lit_col_fill_addr", arr_addr, 3);
    chk("lit_col_fill_tag",  arr_tag,  4'h5);
    chk("lit_col_fill_vbit", arr_vbit, 1);
    tick();
    tick();

    // Capture: tag 7 accepted, then the input changes to F.
    fill_valid = 1'b1; fill_index = 2'd0; fill_tag = 4'h7;
    tick();
    fill_valid = 1'b0; fill_tag = 4'hF;
    #1;
    chk("lit_hold_tag", arr_tag, 4'h7);
    tick();
    chk("lit_hold_tag2", arr_tag, 4'h7);
    tick();

    // Reset mid-sweep.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("lit_rs_addr0", arr_addr, 0);
    tick();
    chk("lit_rs_addr1", arr_addr, 1);
    rst_n = 1'b0;
    tick();
    chk("lit_rs_we0", arr_we, 0);
    rst_n = 1'b1;
    tick();
    chk("lit_rs_restart", arr_addr, 0);
    chk("lit_rs_we1",     arr_we,   1);

    // Randomized phase.
    fpend = 1'b0; ipend = 1'b0; rst_cnt = 0;
    for (int c = 0; c < 4000; c++) begin
      if (rst_cnt > 0) begin
        rst_n = 1'b0; rst_cnt--;
      end else if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0; rst_cnt = $urandom_range(0, 2);
      end else begin
        rst_n = 1'b1;
      end
      if (!fpend) begin
        fill_tag   = TAG_W'($urandom);
        fill_index = INDEX_W'($urandom);
        fpend      = ($urandom_range(0, 2) == 0);
      end
      if (!ipend) begin
        inval_index = INDEX_W'($urandom);
        ipend       = ($urandom_range(0, 5) == 0);
      end
      fill_valid  = fpend;
      inval_valid = ipend;
      #1;
      acc_f = fill_valid && fill_ready && rst_n;
      acc_i = inval_valid && inval_ready && rst_n;
      tick();
      if (acc_f) fpend = 1'b0;
      if (acc_i) ipend = 1'b0;
    end
    fill_valid = 1'b0; inval_valid = 1'b0;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
